sipo_deframer: RTL
==================

// Module: sipo_deframer
// PURPOSE
//  Serial-to-parallel receiver; sits directly downstream of the piso serializer.
//  Collects WIDTH serial bits into a word, aligned by a start-of-frame strobe.
//  Presents each completed word on a ready/valid output port.
//  Flags words dropped because the consumer stalled.
// PARAMETERS
//  WIDTH      4  bits per word (>=2)
//  MSB_FIRST  1  1: first received bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0]
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  reset       in   1      asynchronous, active-high; clears all state
//  din         in   1      serial data bit
//  bit_en      in   1      din is valid this cycle
//  sof         in   1      with bit_en: this din is the first bit of a new word
//  dout        out  WIDTH  assembled word; stable while dout_valid=1
//  dout_valid  out  1      word available
//  dout_ready  in   1      consumer accepts the word when dout_valid&&dout_ready at an edge
//  overrun     out  1      sticky: a completed word was dropped
//  busy        out  1      1 when the FSM is in SHIFT (framing locked)
// BEHAVIOUR
//  Reset values
//   - state=IDLE, bit count=0, shift reg=0.
//   - dout=0, dout_valid=0, overrun=0, busy=0.
//  Reset may assert at any time; a partial word is discarded with no output.
//  FSM states: IDLE (unaligned), SHIFT (aligned).
//  - IDLE: bit_en&&!sof is ignored.
//  - IDLE: bit_en&&sof captures din as bit 1 (cnt=1) and moves to SHIFT.
//  - SHIFT: bit_en&&!sof shifts din in and increments cnt.
//  - SHIFT: bit_en&&sof resyncs; the partial word is dropped and din becomes bit 1 (cnt=1).
//    Overrun is not set on a resync.
//  - SHIFT: cycles with bit_en=0 hold all state; there is no timeout.
//  Word completion
//   - Occurs on the edge sampling the WIDTH-th bit. cnt wraps to 0 and the FSM stays in SHIFT.
//   - Subsequent bits form the next word without needing sof.
//   - Latency: dout_valid is high in the cycle after the last bit is presented.
//   - If the output slot is free, or dout_valid&&dout_ready at this edge: dout<=word, dout_valid<=1.
//   - If dout_valid&&!dout_ready: word dropped, dout held, overrun<=1.
//  Output handshake
//   - At an edge with dout_valid&&dout_ready and no completion: dout_valid<=0.
//   - dout is not cleared when the word is accepted.
//  overrun clears only on reset.
//  Bit order: with MSB_FIRST=1, the bit sequence 1,0,1,0 gives dout=4'b1010.
//  Internal: cnt is $clog2(WIDTH+1) bits; it never exceeds WIDTH-1 between words.
// STRUCTURE
//  Shared include serial_defs.vh
//   - FSM localparams ST_IDLE=1'b0, ST_SHIFT=1'b1.
//   - Default word width SER_WIDTH=4, shared with piso.
//  Sub-module sipo_shift
//   - Contains the shift register, bit counter and FSM.
//   - Emits a one-cycle word_done pulse together with word[WIDTH-1:0].
//  Top level adds the output holding register, the handshake and overrun logic.
// TESTING
//  1 Reset mid-word: send bits 1,0 after sof, then pulse reset.
//    -> all outputs 0, busy=0; bits without sof afterwards are ignored.
//  2 Basic word, dout_ready=1: sof+1, then 0,1,0.
//    -> dout=4'b1010 with a 1-cycle dout_valid pulse the cycle after the 4th bit.
//  3 Back-to-back: 8 consecutive bits 1,0,1,0,0,1,1,0, sof on the first bit only.
//    -> words 4'b1010 then 4'b0110, overrun=0.
//  4 Stall: dout_ready=0 across two complete words.
//    -> dout holds 4'b1010, overrun=1 after the second word.
//    Then dout_ready=1 -> dout_valid drops.
//  5 Resync: sof+1, 1, then sof+0, 0, 1, 1.
//    -> single word 4'b0011, no overrun.
//  6 Gaps and simultaneous events: bit_en low between bits gives the same result as case 2.
//    Completion in the same cycle as dout_ready=1 -> the new word is loaded and dout_valid stays 1.

Source files
------------

// File: rtl/sipo_deframer_pkg.sv
// Shared serial-link definitions: FSM encodings and the default word width
// common to the serializer and this deframer.
package sipo_deframer_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  localparam int         SER_WIDTH = 4;

endpackage

// File: rtl/sipo_shift.sv
// Framing FSM, bit counter and shift register. Emits a combinational
// word_done pulse with the completed word on the edge that samples its last bit.
module sipo_shift
  import sipo_deframer_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             bit_en,
  input  logic             sof,
  output logic             word_done,
  output logic [WIDTH-1:0] word,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] seed, shifted;

  // seed places a sof bit as bit 1 of a fresh word; shifted appends din
  assign seed    = MSB_FIRST ? {{(WIDTH-1){1'b0}}, din} : {din, {(WIDTH-1){1'b0}}};
  assign shifted = MSB_FIRST ? {sh_q[WIDTH-2:0], din}   : {din, sh_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    word_done = 1'b0;
    if (bit_en) begin
      if (sof) begin
        state_d = ST_SHIFT;
        cnt_d   = CW'(1);
        sh_d    = seed;
      end else if (state_q == ST_SHIFT) begin
        sh_d = shifted;
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          word_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  assign word = sh_d;
  assign busy = (state_q == ST_SHIFT);

endmodule

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: word assembly in sipo_shift, plus a one-word
// ready/valid output slot and a sticky overrun flag for words lost to stalls.
module sipo_deframer
  import sipo_deframer_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             bit_en,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             busy
);

  logic             word_done;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;

  sipo_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .bit_en    (bit_en),
    .sof       (sof),
    .word_done (word_done),
    .word      (word),
    .busy      (busy)
  );

  // A completing word may replace one being accepted on the same edge.
  always_comb begin
    dout_d = dout_q;
    vld_d  = vld_q;
    ovr_d  = ovr_q;
    if (word_done) begin
      if (!vld_q || dout_ready) begin
        dout_d = word;
        vld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && dout_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign overrun    = ovr_q;

endmodule
